// File: rtl/dmem_pkg.sv
// Shared widths, FSM state encoding and read-tracker entry layout for the data-memory controller.
package dmem_pkg;
    localparam int WORD_W    = 16;
    localparam int VEC_LANES = 16;
    localparam int VEC_W     = 256;
    localparam int MEM_AW    = 18;
    localparam int LANE_W    = 4;

    typedef enum logic [2:0] {
        IDLE,
        V_WR,
        V_RD,
        V_DRAIN,
        V_DONE
    } dmem_state_t;

    typedef struct packed {
        logic              vld;
        logic              is_vec;
        logic [LANE_W-1:0] lane;
    } trk_entry_t;
endpackage

// File: rtl/dmem_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter; combinational grant, priority flips after each grant.
// After reset, requester 0 wins the first contested cycle.
module rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);
    logic last1;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (en) begin
            if (req0 && req1) begin
                gnt0 = last1;
                gnt1 = !last1;
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last1 <= 1'b1;
        end else if (gnt0) begin
            last1 <= 1'b0;
        end else if (gnt1) begin
            last1 <= 1'b1;
        end
    end
endmodule

// File: rtl/dmem_ctrl.sv
// Scalar/vector access controller for a single-port 16-bit buffer: scalars pass in one cycle from IDLE,
// vectors become 16 word beats; a RD_LAT-deep tracker steers returning read words to their owner.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_req,
    input  logic              s_we,
    input  logic [31:0]       s_addr,
    input  logic [WORD_W-1:0] s_wdata,
    output logic              s_gnt,
    output logic              s_rvalid,
    output logic [WORD_W-1:0] s_rdata,
    input  logic              v_req,
    input  logic              v_we,
    input  logic [31:0]       v_addr,
    input  logic [VEC_W-1:0]  v_wdata,
    output logic              v_gnt,
    output logic              v_done,
    output logic [VEC_W-1:0]  v_rdata,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_we,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata
);
    dmem_state_t       state;
    logic [LANE_W-1:0] cnt;
    logic [MEM_AW-1:0] base;
    logic [VEC_W-1:0]  wbuf;
    logic [WORD_W-1:0] s_rdata_q;
    trk_entry_t        trk [RD_LAT];
    trk_entry_t        issue;
    trk_entry_t        tail;
    logic              arb_en;
    logic              unused_addr_hi;

    assign unused_addr_hi = ^{s_addr[31:MEM_AW], v_addr[31:MEM_AW]};
    assign arb_en         = (state == IDLE);
    assign tail           = trk[RD_LAT-1];

    rr_arb2 u_arb (
        .clk  (clk),
        .rst  (rst),
        .en   (arb_en),
        .req0 (s_req),
        .req1 (v_req),
        .gnt0 (s_gnt),
        .gnt1 (v_gnt)
    );

    // Vector beats own the port outside IDLE; the vector grant cycle itself leaves memory idle.
    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (state == V_WR || state == V_RD) begin
            mem_addr  = base + MEM_AW'(cnt);
            mem_we    = (state == V_WR);
            mem_wdata = (state == V_WR) ? wbuf[WORD_W-1:0] : '0;
        end else if (s_gnt) begin
            mem_addr  = s_addr[MEM_AW-1:0];
            mem_we    = s_we;
            mem_wdata = s_wdata;
        end
    end

    always_comb begin
        issue = '0;
        if (state == V_RD) begin
            issue.vld    = 1'b1;
            issue.is_vec = 1'b1;
            issue.lane   = cnt;
        end else if (s_gnt && !s_we) begin
            issue.vld = 1'b1;
        end
    end

    assign s_rvalid = tail.vld && !tail.is_vec;
    assign s_rdata  = s_rvalid ? mem_rdata : s_rdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) trk[i] <= '0;
            s_rdata_q <= '0;
            v_rdata   <= '0;
        end else begin
            trk[0] <= issue;
            for (int i = 1; i < RD_LAT; i++) trk[i] <= trk[i-1];
            if (s_rvalid) s_rdata_q <= mem_rdata;
            if (tail.vld && tail.is_vec) v_rdata[{tail.lane, 4'b0000} +: WORD_W] <= mem_rdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            base   <= '0;
            wbuf   <= '0;
            v_done <= 1'b0;
        end else begin
            v_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (v_gnt) begin
                        base  <= v_addr[MEM_AW-1:0];
                        wbuf  <= v_wdata;
                        cnt   <= '0;
                        state <= v_we ? V_WR : V_RD;
                    end
                end
                V_WR, V_RD: begin
                    // Lane k always sits in the low word of wbuf during beat k.
                    cnt  <= cnt + 1'b1;
                    wbuf <= wbuf >> WORD_W;
                    if (cnt == LANE_W'(VEC_LANES - 1)) begin
                        if (state == V_WR) begin
                            state  <= V_DONE;
                            v_done <= 1'b1;
                        end else begin
                            state <= V_DRAIN;
                        end
                    end
                end
                V_DRAIN: begin
                    if (tail.vld && tail.is_vec && tail.lane == LANE_W'(VEC_LANES - 1)) begin
                        state  <= V_DONE;
                        v_done <= 1'b1;
                    end
                end
                V_DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench: three controllers (RD_LAT 1..3) share stimulus and one memory model.
module tb_dmem_ctrl;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         s_req = 1'b0, s_we = 1'b0;
    logic [31:0]  s_addr = '0;
    logic [15:0]  s_wdata = '0;
    logic         v_req = 1'b0, v_we = 1'b0;
    logic [31:0]  v_addr = '0;
    logic [255:0] v_wdata = '0;

    logic         s_gnt_o [3];
    logic         s_rvalid_o [3];
    logic [15:0]  s_rdata_o [3];
    logic         v_gnt_o [3];
    logic         v_done_o [3];
    logic [255:0] v_rdata_o [3];
    logic [17:0]  mem_addr_o [3];
    logic         mem_we_o [3];
    logic [15:0]  mem_wdata_o [3];
    logic [15:0]  mem_rdata_o [3];

    logic [15:0]  mem [0:262143];

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    int vdone_cyc [3];
    int vdone_cnt [3];

    typedef struct {int inst; int cyc; logic [15:0] dat;} rv_t;
    typedef struct {int cyc; logic [17:0] addr; logic [15:0] dat;} wr_t;
    rv_t rvq [$];
    wr_t wrq [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar i = 0; i < 3; i++) begin : g_dut
        logic [15:0] rl [i+1];
        dmem_ctrl #(.RD_LAT(i + 1)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .s_req     (s_req),
            .s_we      (s_we),
            .s_addr    (s_addr),
            .s_wdata   (s_wdata),
            .s_gnt     (s_gnt_o[i]),
            .s_rvalid  (s_rvalid_o[i]),
            .s_rdata   (s_rdata_o[i]),
            .v_req     (v_req),
            .v_we      (v_we),
            .v_addr    (v_addr),
            .v_wdata   (v_wdata),
            .v_gnt     (v_gnt_o[i]),
            .v_done    (v_done_o[i]),
            .v_rdata   (v_rdata_o[i]),
            .mem_addr  (mem_addr_o[i]),
            .mem_we    (mem_we_o[i]),
            .mem_wdata (mem_wdata_o[i]),
            .mem_rdata (mem_rdata_o[i])
        );
        always @(posedge clk) begin
            rl[0] <= mem[mem_addr_o[i]];
            for (int j = 1; j <= i; j++) rl[j] <= rl[j-1];
        end
        assign mem_rdata_o[i] = rl[i];
    end

    // Writes are identical across instances, so one port updates the shared array.
    always @(posedge clk) if (mem_we_o[0]) mem[mem_addr_o[0]] <= mem_wdata_o[0];

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (v_done_o[i]) begin
                vdone_cyc[i] = cyc;
                vdone_cnt[i] = vdone_cnt[i] + 1;
            end
            if (s_rvalid_o[i]) rvq.push_back('{i, cyc, s_rdata_o[i]});
        end
        if (mem_we_o[1]) wrq.push_back('{cyc, mem_addr_o[1], mem_wdata_o[1]});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({s_gnt_o[i], s_rvalid_o[i], v_gnt_o[i], v_done_o[i], mem_we_o[i], s_rdata_o[i],
                 mem_addr_o[i], mem_wdata_o[i]} !== '0) begin
                failures++;
                $display("FAIL reset_ctrl inst=%0d got=%0h exp=0", i,
                         {s_gnt_o[i], s_rvalid_o[i], v_gnt_o[i], v_done_o[i], mem_we_o[i],
                          s_rdata_o[i], mem_addr_o[i], mem_wdata_o[i]});
            end
        end
        checks++;
        if (v_rdata_o[1] !== '0) begin
            failures++;
            $display("FAIL reset_v_rdata got=%0h exp=0", v_rdata_o[1]);
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_scalar();
        int n;
        s_req = 1'b1; s_we = 1'b1; s_addr = 32'hFFFC_0010; s_wdata = 16'h1234;
        @(negedge clk);
        checks++;
        if ({s_gnt_o[1], v_gnt_o[1], mem_we_o[1], mem_addr_o[1], mem_wdata_o[1]} !== {3'b101, 18'h00010, 16'h1234}) begin
            failures++;
            $display("FAIL scalar_write got gnt=%0b we=%0b addr=%0h wd=%0h exp gnt=1 we=1 addr=10 wd=1234",
                     s_gnt_o[1], mem_we_o[1], mem_addr_o[1], mem_wdata_o[1]);
        end
        tick();
        s_we = 1'b0; s_addr = 32'h0000_0010;
        n = cyc;
        rvq.delete();
        @(negedge clk);
        checks++;
        if ({s_gnt_o[1], mem_we_o[1], mem_addr_o[1]} !== {2'b10, 18'h00010}) begin
            failures++;
            $display("FAIL scalar_read_issue got gnt=%0b we=%0b addr=%0h exp gnt=1 we=0 addr=10",
                     s_gnt_o[1], mem_we_o[1], mem_addr_o[1]);
        end
        tick();
        s_req = 1'b0;
        repeat (5) tick();
        for (int i = 0; i < 3; i++) begin
            int found = 0;
            int gc = -1;
            logic [15:0] gd = '0;
            foreach (rvq[j]) if (rvq[j].inst == i) begin found++; gc = rvq[j].cyc; gd = rvq[j].dat; end
            checks++;
            if (found != 1 || gc != n + i + 1 || gd !== 16'h1234) begin
                failures++;
                $display("FAIL scalar_return lat=%0d got n=%0d cyc=%0d data=%0h exp n=1 cyc=%0d data=1234",
                         i + 1, found, gc, gd, n + i + 1);
            end
        end
    endtask

    task automatic test_vec_write(input logic [17:0] base, input logic [15:0] seed, input string name);
        int g, dc, bad;
        for (int k = 0; k < 16; k++) v_wdata[k*16 +: 16] = seed + 16'(k);
        v_req = 1'b1; v_we = 1'b1; v_addr = {14'h2AAA, base};
        g = cyc;
        dc = vdone_cnt[1];
        wrq.delete();
        @(negedge clk);
        checks++;
        if ({v_gnt_o[1], s_gnt_o[1], mem_we_o[1]} !== 3'b100) begin
            failures++;
            $display("FAIL %s_grant got vgnt=%0b sgnt=%0b we=%0b exp vgnt=1 sgnt=0 we=0",
                     name, v_gnt_o[1], s_gnt_o[1], mem_we_o[1]);
        end
        tick();
        v_req = 1'b0;
        for (int t = 0; t < 30 && vdone_cnt[1] == dc; t++) tick();
        checks++;
        if (vdone_cnt[1] != dc + 1 || vdone_cyc[1] != g + 17) begin
            failures++;
            $display("FAIL %s_done got cnt=%0d cyc=%0d exp cnt=%0d cyc=%0d",
                     name, vdone_cnt[1] - dc, vdone_cyc[1], 1, g + 17);
        end
        bad = 0;
        if (wrq.size() != 16) bad = 99;
        else for (int k = 0; k < 16; k++)
            if (wrq[k].cyc != g + 1 + k || wrq[k].addr !== base + 18'(k) || wrq[k].dat !== seed + 16'(k)) bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL %s_beats got bad=%0d writes=%0d exp bad=0 writes=16", name, bad, wrq.size());
        end
    endtask

    task automatic test_scalar_burst();
        int n0, miss, idx, bad;
        rvq.delete();
        n0 = cyc;
        miss = 0;
        for (int k = 0; k < 16; k++) begin
            s_req = 1'b1; s_we = 1'b0; s_addr = 32'h0000_0100 + k;
            @(negedge clk);
            if (s_gnt_o[1] !== 1'b1) miss++;
            tick();
        end
        s_req = 1'b0;
        checks++;
        if (miss != 0) begin
            failures++;
            $display("FAIL burst_grants got missed=%0d exp 0", miss);
        end
        repeat (6) tick();
        idx = 0;
        bad = 0;
        foreach (rvq[j]) if (rvq[j].inst == 1) begin
            if (rvq[j].cyc != n0 + idx + 2 || rvq[j].dat !== 16'h0A00 + 16'(idx)) bad++;
            idx++;
        end
        checks++;
        if (idx != 16 || bad != 0) begin
            failures++;
            $display("FAIL burst_returns got n=%0d bad=%0d exp n=16 bad=0", idx, bad);
        end
    endtask

    task automatic test_vec_read();
        int g;
        int dc [3];
        logic [255:0] expv;
        for (int k = 0; k < 16; k++) expv[k*16 +: 16] = 16'h0A00 + 16'(k);
        for (int i = 0; i < 3; i++) dc[i] = vdone_cnt[i];
        wrq.delete();
        v_req = 1'b1; v_we = 1'b0; v_addr = 32'h0000_0100;
        g = cyc;
        @(negedge clk);
        checks++;
        if (v_gnt_o[1] !== 1'b1) begin
            failures++;
            $display("FAIL vread_grant got=%0b exp=1", v_gnt_o[1]);
        end
        tick();
        v_req = 1'b0;
        for (int t = 0; t < 40 && vdone_cnt[2] == dc[2]; t++) tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (vdone_cnt[i] != dc[i] + 1 || vdone_cyc[i] != g + 18 + i) begin
                failures++;
                $display("FAIL vread_done lat=%0d got cnt=%0d cyc=%0d exp cnt=1 cyc=%0d",
                         i + 1, vdone_cnt[i] - dc[i], vdone_cyc[i], g + 18 + i);
            end
            checks++;
            if (v_rdata_o[i] !== expv) begin
                failures++;
                $display("FAIL vread_data lat=%0d got=%0h exp=%0h", i + 1, v_rdata_o[i], expv);
            end
        end
        checks++;
        if (wrq.size() != 0) begin
            failures++;
            $display("FAIL vread_no_write got writes=%0d exp 0", wrq.size());
        end
    endtask

    task automatic test_arb();
        int c0, stray;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        s_req = 1'b1; s_we = 1'b1; s_addr = 32'h0000_0200; s_wdata = 16'h5555;
        v_req = 1'b1; v_we = 1'b1; v_addr = 32'h0000_0300;
        c0 = cyc;
        @(negedge clk);
        checks++;
        if ({s_gnt_o[1], v_gnt_o[1]} !== 2'b10) begin
            failures++;
            $display("FAIL arb_first got s=%0b v=%0b exp s=1 v=0", s_gnt_o[1], v_gnt_o[1]);
        end
        tick();
        s_addr = 32'h0000_0201; s_wdata = 16'h6666;
        @(negedge clk);
        checks++;
        if ({s_gnt_o[1], v_gnt_o[1], mem_we_o[1]} !== 3'b010) begin
            failures++;
            $display("FAIL arb_second got s=%0b v=%0b we=%0b exp s=0 v=1 we=0", s_gnt_o[1], v_gnt_o[1], mem_we_o[1]);
        end
        tick();
        v_req = 1'b0;
        stray = 0;
        for (int t = 0; t < 17; t++) begin
            @(negedge clk);
            if (s_gnt_o[1] !== 1'b0) stray++;
            tick();
        end
        checks++;
        if (stray != 0) begin
            failures++;
            $display("FAIL arb_no_sgnt_in_vector got=%0d exp=0", stray);
        end
        @(negedge clk);
        checks++;
        if (cyc != c0 + 19 || {s_gnt_o[1], mem_we_o[1], mem_addr_o[1], mem_wdata_o[1]} !== {2'b11, 18'h00201, 16'h6666}) begin
            failures++;
            $display("FAIL arb_third got cyc=%0d gnt=%0b addr=%0h wd=%0h exp cyc=%0d gnt=1 addr=201 wd=6666",
                     cyc, s_gnt_o[1], mem_addr_o[1], mem_wdata_o[1], c0 + 19);
        end
        tick();
        s_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_abort();
        int dc, bad;
        for (int k = 0; k < 16; k++) v_wdata[k*16 +: 16] = 16'hC000 + 16'(k);
        v_req = 1'b1; v_we = 1'b1; v_addr = 32'h0000_0400;
        dc = vdone_cnt[1];
        wrq.delete();
        tick();
        v_req = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({s_gnt_o[1], s_rvalid_o[1], v_gnt_o[1], v_done_o[1], mem_we_o[1], s_rdata_o[1],
             v_rdata_o[1], mem_addr_o[1], mem_wdata_o[1]} !== '0) begin
            failures++;
            $display("FAIL abort_outputs got we=%0b addr=%0h wd=%0h done=%0b exp all 0",
                     mem_we_o[1], mem_addr_o[1], mem_wdata_o[1], v_done_o[1]);
        end
        tick();
        rst = 1'b0;
        repeat (25) tick();
        checks++;
        if (vdone_cnt[1] != dc) begin
            failures++;
            $display("FAIL abort_no_done got=%0d exp=0", vdone_cnt[1] - dc);
        end
        bad = 0;
        if (wrq.size() != 5) bad = 99;
        else for (int k = 0; k < 5; k++)
            if (wrq[k].addr !== 18'h400 + 18'(k) || wrq[k].dat !== 16'hC000 + 16'(k)) bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL abort_writes got bad=%0d writes=%0d exp bad=0 writes=5", bad, wrq.size());
        end
        rvq.delete();
        s_req = 1'b1; s_we = 1'b0; s_addr = 32'h0000_0404;
        @(negedge clk);
        checks++;
        if (s_gnt_o[1] !== 1'b1) begin
            failures++;
            $display("FAIL abort_idle_grant got=%0b exp=1", s_gnt_o[1]);
        end
        tick();
        s_req = 1'b0;
        repeat (5) tick();
        checks++;
        if (rvq.size() != 3 || rvq[0].dat !== 16'hC004) begin
            failures++;
            $display("FAIL abort_last_beat got n=%0d exp n=3 data=c004", rvq.size());
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            vdone_cyc[i] = -1;
            vdone_cnt[i] = 0;
        end
        test_reset();
        test_scalar();
        test_vec_write(18'h00100, 16'h0A00, "vwrite");
        tick();
        test_scalar_burst();
        test_vec_read();
        test_arb();
        test_vec_write(18'h3FFF8, 16'hB000, "wrap");
        tick();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory access controller between the load/store stage and the single-port 16-bit data buffer. Arbitrates between a scalar requester (one 16-bit word) and a vector requester (256-bit, 16 lanes), serializing each vector access into 16 consecutive word beats on the memory port. Also tracks read latency so that returned words reach the right requester.

## Interface
- RD_LAT, 1: memory read latency in cycles from address presentation to valid mem_rdata (legal 1..3).
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_req  in  1  scalar request; held with operands until s_gnt.
- s_we  in  1  scalar write (1) / read (0).
- s_addr  in  32  scalar word address; bits [31:18] ignored.
- s_wdata  in  16  scalar write data.
- s_gnt  out  1  scalar accepted; memory driven this cycle.
- s_rvalid  out  1  scalar read data valid, single-cycle pulse.
- s_rdata  out  16  scalar read data.
- v_req  in  1  vector request; held with operands until v_gnt.
- v_we  in  1  vector write / read.
- v_addr  in  32  lane-0 word address; bits [31:18] ignored.
- v_wdata  in  256  lane k at bits [16k+15:16k].
- v_gnt  out  1  vector accepted; operands latched, single-cycle pulse.
- v_done  out  1  vector transaction complete, single-cycle pulse.
- v_rdata  out  256  assembled vector read data.
- mem_addr  out  18  word address to buffer.
- mem_we  out  1  buffer write enable.
- mem_wdata  out  16  buffer write data.
- mem_rdata  in  16  buffer read data.

## Operation
- FSM states: IDLE, V_WR, V_RD, V_DRAIN, V_DONE.
- IDLE: scalar accesses handled without leaving IDLE; s_gnt combinational; mem_addr=s_addr[17:0], mem_we=s_we, mem_wdata=s_wdata. Back-to-back scalar grants at 1/cycle allowed.
- Arbitration in IDLE only: one requester → grant it; both → grant the one not granted last (round-robin flag; reset value makes scalar win first). No grant in any other state.
- Vector grant (cycle G): latch base=v_addr[17:0], we, wdata; counter k=0; go V_WR or V_RD. Memory idle in G.
- V_WR/V_RD: beat k per cycle, mem_addr=(base+k) mod 2^18, mem_wdata=lane k (writes), mem_we=we. After k=15: V_WR→V_DONE; V_RD→V_DRAIN.
- Read return tracking: RD_LAT-deep shift register of {valid, is_vector, lane}; at return, scalar → s_rvalid/s_rdata; vector → write lane into v_rdata register.
- V_DRAIN: wait until lane 15 captured, then V_DONE. V_DONE: v_done=1 one cycle, →IDLE.
- v_rdata holds value until the next vector read's lane 0 capture; vector writes leave it unchanged.
- Address wrap: base+k wraps mod 2^18 (0x3FFFF → 0x00000).
- Reset (any state, async): state=IDLE, counter=0, tracking pipe cleared, rr flag favours scalar, v_rdata=0. Aborted vector writes leave already-written beats in memory; no v_done.
- Reset values: s_gnt, s_rvalid, v_gnt, v_done, mem_we = 0; s_rdata, v_rdata, mem_addr, mem_wdata = 0.

## Timing
- Scalar: grant N → mem access N → s_rvalid at N+RD_LAT (reads only).
- Vector write: v_gnt G, beats G+1..G+16, v_done G+17, next grant possible G+18.
- Vector read: beats G+1..G+16, lane 15 captured at G+16+RD_LAT, v_done G+17+RD_LAT with v_rdata valid.
- Scalar read granted at N ≤ G−1 returns before any vector lane; tracker keeps them separate.
- s_rdata, v_rdata registered; s_gnt, mem_* driven combinationally in IDLE, from registers otherwise.

## Structure
- Package dmem_pkg: WORD_W=16, VEC_LANES=16, VEC_W=256, MEM_AW=18, state enum dmem_state_t, tracker entry struct.
- Sub-module rr_arb2: two-requester round-robin arbiter with enable and update-on-grant; everything else in dmem_ctrl.

## Test plan
- Scalar write 0x1234 to 0x00010, then read 0x00010 → s_gnt same cycle as request, s_rvalid=1 with s_rdata=0x1234 RD_LAT cycles later.
- Vector write lanes k=0x0A00+k to base 0x00100, then scalar reads 0x00100..0x0010F → each returns 0x0A00+k; v_done exactly at G+17.
- Vector read of same region → v_done at G+17+RD_LAT, v_rdata lane k = 0x0A00+k; repeat with RD_LAT=1,2,3.
- s_req and v_req both high from reset for three transactions → order scalar, vector, scalar; no s_gnt during V_* states.
- Vector write at base 0x3FFF8 → beats at 0x3FFF8..0x3FFFF then 0x00000..0x00007 with correct lanes.
- Assert rst at beat 5 of a vector write → next cycle all outputs 0, state IDLE, no v_done; only addresses base..base+4 modified.
